// File: rtl/adder_err_pkg.sv
// Shared constants, FSM state type and width helper for the adder error monitor.
// Optional feature macro: ADDER_ERR_SQUARED_EN (see adder_error_monitor.sv).
package adder_err_pkg;

  localparam int unsigned SUM_W_DEF = 17;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of the error-distance accumulator; wide enough that a full window never overflows.
  function automatic int unsigned acc_w(input int unsigned sum_w, input int unsigned cnt_w);
    return sum_w + cnt_w;
  endfunction

endpackage

// File: rtl/adder_err_dist.sv
// Absolute error distance between two adder sums, plus a nonzero flag.
// Purely combinational; used as the first pipeline stage of the monitor.
module adder_err_dist
  import adder_err_pkg::*;
#(
  parameter int unsigned W = SUM_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] ed,
  output logic         ne
);

  logic signed [W:0] diff;
  logic        [W:0] mag;

  // One-bit-wider signed difference, then magnitude; |a-b| always fits in W bits.
  always_comb begin
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
    ed   = mag[W-1:0];
    ne   = |mag;
  end

endmodule

// File: rtl/adder_error_monitor.sv
// Accumulates error statistics (error count, sum and maximum of error distance)
// between paired exact/approximate adder sums over a programmed sample window.
// Optional feature macro: ADDER_ERR_SQUARED_EN adds the sum_sq_ed output
// (sum of squared error distance) with unchanged latency.
module adder_error_monitor
  import adder_err_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [CNT_W-1:0]                  num_samples,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SUM_W-1:0]                  exact_sum,
  input  logic [SUM_W-1:0]                  approx_sum,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_W-1:0]                  err_cnt,
  output logic [acc_w(SUM_W, CNT_W)-1:0]    sum_ed,
  output logic [SUM_W-1:0]                  max_ed
`ifdef ADDER_ERR_SQUARED_EN
  , output logic [2*SUM_W+CNT_W-1:0]        sum_sq_ed
`endif
);

  localparam int unsigned ACC_W = acc_w(SUM_W, CNT_W);
`ifdef ADDER_ERR_SQUARED_EN
  localparam int unsigned SQ_W    = 2 * SUM_W;
  localparam int unsigned SQACC_W = 2 * SUM_W + CNT_W;
`endif

  state_t           state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] accepted;
  logic             xfer;
  logic             clear;

  logic [SUM_W-1:0] ed;
  logic             ne;
  logic             s1_valid;
  logic [SUM_W-1:0] s1_ed;
  logic             s1_ne;
`ifdef ADDER_ERR_SQUARED_EN
  logic [SQ_W-1:0]  s1_sq;
`endif

  assign in_ready = (state == RUN) && (accepted < target);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign xfer     = in_valid && in_ready;
  assign clear    = start && ((state == IDLE) || (state == DONE));

  adder_err_dist #(.W(SUM_W)) u_dist (
    .a  (exact_sum),
    .b  (approx_sum),
    .ed (ed),
    .ne (ne)
  );

  // Window control: start latches the target, transfers count up, drain waits for S1 to empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= '0;
      accepted <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            target   <= num_samples;
            accepted <= '0;
            state    <= (num_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            accepted <= accepted + CNT_W'(1);
            if (accepted + CNT_W'(1) == target) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage datapath: S1 registers the error distance, S2 folds it into the statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ed     <= '0;
      s1_ne     <= 1'b0;
      err_cnt   <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
`ifdef ADDER_ERR_SQUARED_EN
      s1_sq     <= '0;
      sum_sq_ed <= '0;
`endif
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_ed <= ed;
        s1_ne <= ne;
`ifdef ADDER_ERR_SQUARED_EN
        s1_sq <= SQ_W'(ed) * SQ_W'(ed);
`endif
      end
      // clear only fires in IDLE/DONE, where S1 is always empty, so the two never collide.
      if (clear) begin
        err_cnt   <= '0;
        sum_ed    <= '0;
        max_ed    <= '0;
`ifdef ADDER_ERR_SQUARED_EN
        sum_sq_ed <= '0;
`endif
      end else if (s1_valid) begin
        err_cnt <= err_cnt + CNT_W'(s1_ne);
        sum_ed  <= sum_ed + ACC_W'(s1_ed);
        if (s1_ed > max_ed) max_ed <= s1_ed;
`ifdef ADDER_ERR_SQUARED_EN
        sum_sq_ed <= sum_sq_ed + SQACC_W'(s1_sq);
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Self-checking bench for adder_error_monitor: expected window statistics are
// computed from the driven pairs, queued, and compared when done rises.
module tb_adder_error_monitor;

  localparam int unsigned SUM_W = 17;
  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [CNT_W-1:0]       cnt;
    logic [SUM_W+CNT_W-1:0] sum;
    logic [SUM_W-1:0]       mx;
    logic [2*SUM_W+CNT_W-1:0] sq;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [CNT_W-1:0]         num_samples = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [SUM_W-1:0]         exact_sum = '0;
  logic [SUM_W-1:0]         approx_sum = '0;
  logic                     busy;
  logic                     done;
  logic [CNT_W-1:0]         err_cnt;
  logic [SUM_W+CNT_W-1:0]   sum_ed;
  logic [SUM_W-1:0]         max_ed;
`ifdef ADDER_ERR_SQUARED_EN
  logic [2*SUM_W+CNT_W-1:0] sum_sq_ed;
`endif

  int   asserts = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [SUM_W-1:0] pa[16];
  logic [SUM_W-1:0] pb[16];

  adder_error_monitor #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .exact_sum   (exact_sum),
    .approx_sum  (approx_sum),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed)
`ifdef ADDER_ERR_SQUARED_EN
    , .sum_sq_ed (sum_sq_ed)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Advance one cycle; everything is driven and sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [SUM_W-1:0] absd(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Scoreboard push: reference statistics for pairs 0..n-1.
  task automatic expect_window(input int n);
    exp_t e;
    logic [2*SUM_W+CNT_W-1:0] dd;
    e.cnt = '0; e.sum = '0; e.mx = '0; e.sq = '0;
    for (int i = 0; i < n; i++) begin
      dd = {{(SUM_W+CNT_W){1'b0}}, absd(pa[i], pb[i])};
      if (dd != 0) e.cnt = e.cnt + 1'b1;
      e.sum = e.sum + dd[SUM_W+CNT_W-1:0];
      if (dd[SUM_W-1:0] > e.mx) e.mx = dd[SUM_W-1:0];
      e.sq = e.sq + dd * dd;
    end
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    num_samples = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  // Present one pair and hold it until accepted (bounded); in_valid stays high afterwards.
  task automatic send_pair(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
    int k;
    in_valid = 1'b1;
    exact_sum = a;
    approx_sum = b;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      asserts++; failures++;
      $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    tick();
  endtask

  // Scoreboard pop: wait for done (bounded), check latency and statistics.
  task automatic check_window(input string tag, input int exp_k);
    exp_t e;
    int k;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    asserts++;
    if (!done || k !== exp_k) begin
      failures++;
      $display("FAIL %s_done_latency: done=%0b after %0d cycles, required 1 after %0d", tag, done, k, exp_k);
    end
    if (exp_q.size() == 0) begin
      asserts++; failures++;
      $display("FAIL %s_scoreboard: queue empty, required 1 entry", tag);
      return;
    end
    e = exp_q.pop_front();
    asserts++;
    if (err_cnt !== e.cnt) begin failures++; $display("FAIL %s_err_cnt: got %0d required %0d", tag, err_cnt, e.cnt); end
    asserts++;
    if (sum_ed !== e.sum) begin failures++; $display("FAIL %s_sum_ed: got %0d required %0d", tag, sum_ed, e.sum); end
    asserts++;
    if (max_ed !== e.mx) begin failures++; $display("FAIL %s_max_ed: got %0d required %0d", tag, max_ed, e.mx); end
`ifdef ADDER_ERR_SQUARED_EN
    asserts++;
    if (sum_sq_ed !== e.sq) begin failures++; $display("FAIL %s_sum_sq_ed: got %0d required %0d", tag, sum_sq_ed, e.sq); end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b required 0", busy); end
    asserts++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b required 0", done); end
    asserts++; if (err_cnt !== '0) begin failures++; $display("FAIL rst_err_cnt: got %0d required 0", err_cnt); end
    asserts++; if (sum_ed !== '0) begin failures++; $display("FAIL rst_sum_ed: got %0d required 0", sum_ed); end
    asserts++; if (max_ed !== '0) begin failures++; $display("FAIL rst_max_ed: got %0d required 0", max_ed); end
    rst_n = 1'b1;
    tick();
    // mid-window reset after 3 transfers
    pulse_start(5);
    send_pair(17'd10, 17'd8);
    send_pair(17'd5, 17'd9);
    send_pair(17'd7, 17'd1);
    in_valid = 1'b0;
    tick();
    asserts++; if (sum_ed === '0) begin failures++; $display("FAIL midrun_sum_ed: got 0 required nonzero before reset"); end
    rst_n = 1'b0;
    tick();
    asserts++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_state: busy=%0b done=%0b required 0 0", busy, done); end
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %0b required 0", in_ready); end
    asserts++; if (err_cnt !== '0 || sum_ed !== '0 || max_ed !== '0) begin
      failures++; $display("FAIL midrst_stats: err_cnt=%0d sum_ed=%0d max_ed=%0d required 0 0 0", err_cnt, sum_ed, max_ed);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exact_match();
    pa[0] = 17'd100;    pb[0] = 17'd100;
    pa[1] = 17'd0;      pb[1] = 17'd0;
    pa[2] = 17'd65535;  pb[2] = 17'd65535;
    pa[3] = 17'd131071; pb[3] = 17'd131071;
    expect_window(4);
    pulse_start(4);
    for (int i = 0; i < 4; i++) send_pair(pa[i], pb[i]);
    in_valid = 1'b0;
    check_window("exact", 2);
  endtask

  task automatic test_mixed_errors();
    pa[0] = 17'd10; pb[0] = 17'd8;
    pa[1] = 17'd5;  pb[1] = 17'd9;
    pa[2] = 17'd7;  pb[2] = 17'd7;
    expect_window(3);
    pulse_start(3);
    for (int i = 0; i < 3; i++) send_pair(pa[i], pb[i]);
    in_valid = 1'b0;
    check_window("mixed", 2);
  endtask

  task automatic test_extremes_backpressure();
    pa[0] = 17'd131071; pb[0] = 17'd0;
    pa[1] = 17'd0;      pb[1] = 17'd131071;
    expect_window(2);
    pulse_start(2);
    send_pair(pa[0], pb[0]);
    in_valid = 1'b0;
    tick();
    send_pair(pa[1], pb[1]);
    exact_sum = 17'd50;
    approx_sum = 17'd1;
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ext_in_ready_after_last: got %0b required 0", in_ready); end
    check_window("extremes", 2);
    in_valid = 1'b0;
  endtask

  task automatic test_zero_window();
    expect_window(0);
    pulse_start(0);
    check_window("zero", 0);
    pa[0] = 17'd3; pb[0] = 17'd1;
    expect_window(1);
    pulse_start(1);
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %0b required 1", busy); end
    send_pair(pa[0], pb[0]);
    in_valid = 1'b0;
    check_window("restart", 2);
  endtask

  task automatic test_ignored_start();
    pa[0] = 17'd10; pb[0] = 17'd8;
    pa[1] = 17'd5;  pb[1] = 17'd9;
    expect_window(2);
    pulse_start(2);
    send_pair(pa[0], pb[0]);
    start = 1'b1;
    num_samples = CNT_W'(5);
    send_pair(pa[1], pb[1]);
    start = 1'b0;
    exact_sum = 17'd99;
    approx_sum = 17'd0;
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ign_in_ready: got %0b required 0", in_ready); end
    check_window("ignored_start", 2);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c0;
    for (int i = 0; i < 8; i++) begin
      pa[i] = SUM_W'($urandom_range(0, 131071));
      pb[i] = (i % 3 == 0) ? pa[i] : SUM_W'($urandom_range(0, 131071));
    end
    expect_window(8);
    pulse_start(8);
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_pair(pa[i], pb[i]);
    in_valid = 1'b0;
    asserts++; if (cyc - c0 !== 8) begin failures++; $display("FAIL b2b_throughput: took %0d cycles required 8", cyc - c0); end
    check_window("b2b", 2);
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_mixed_errors();
    test_extremes_backpressure();
    test_zero_window();
    test_ignored_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/adder_error_monitor.md
Name: adder_error_monitor

Overview:
- Downstream consumer of the 16-bit parallel-prefix adders (exact and approximate variants, 17-bit sum outputs).
- Accepts paired exact/approximate sums over a valid/ready stream and accumulates error statistics over a programmed sample window: error count, sum of error distance, maximum error distance.
- Used in the characterisation harness to produce error rate, MED and worst-case error for each approximate adder.

Parameters:
- SUM_W, 17, width of each adder sum (carry-out included).
- CNT_W, 16, width of sample counters; the window length is at most 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; latches num_samples and clears the statistics; honoured only in IDLE or DONE.
- num_samples  input  CNT_W  window length, sampled with start.
- in_valid  input  1  sample pair valid.
- in_ready  output  1  monitor can accept a pair.
- exact_sum  input  SUM_W  sum from the exact adder.
- approx_sum  input  SUM_W  sum from the approximate adder.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE; results are stable.
- err_cnt  output  CNT_W  number of samples with exact_sum != approx_sum.
- sum_ed  output  SUM_W+CNT_W  sum of |exact_sum - approx_sum|.
- max_ed  output  SUM_W  largest |exact_sum - approx_sum| seen.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE.
  - All counters, accumulators and pipeline valids clear.
  - in_ready=0, busy=0, done=0, err_cnt=0, sum_ed=0, max_ed=0.
  - Reset mid-window discards everything; no partial results are kept.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN.
  - RUN --last sample accepted--> DRAIN.
  - DRAIN --pipeline empty--> DONE.
  - DONE --start--> RUN.
  - start with num_samples=0: go directly to DONE on the next edge with all statistics zero.
- start behaviour:
  - start is ignored in RUN and DRAIN.
  - start in DONE clears the statistics in the same edge that enters RUN.
- Handshake:
  - in_ready = (state==RUN) && (accepted < target); it is registered-state driven only, with no combinational path from in_valid.
  - A transfer occurs when in_valid && in_ready.
  - in_ready falls in the cycle after the final transfer.
- Pipeline, 2 stages:
  - S1 registers ed = |exact_sum - approx_sum|, computed as SUM_W+1-bit signed subtraction then magnitude, plus the flag ne = (ed != 0).
  - S2 updates the statistics: err_cnt += ne, sum_ed += ed, max_ed = max(max_ed, ed).
  - A transfer at cycle t is reflected in the outputs at t+2.
  - done rises 3 cycles after the final transfer: S1, S2, then the DRAIN exit.
- Width rules:
  - sum_ed cannot overflow: it is SUM_W+CNT_W bits wide.
  - err_cnt never exceeds num_samples.
- Back-to-back transfers every cycle are supported at full throughput. in_valid gaps simply stall the window.
- Outputs update during RUN and DRAIN; consumers must use them only while done=1.

Optional Feature:
- Macro ADDER_ERR_SQUARED_EN.
- Defined:
  - Adds output sum_sq_ed, width 2*SUM_W+CNT_W, accumulating ed*ed in S2.
  - The multiply is registered in S1, so latency is unchanged.
  - The output resets and clears with the other statistics.
- Undefined: the port and multiplier are absent; all other behaviour is identical.

Decomposition:
- Package adder_err_pkg holds:
  - SUM_W_DEF and CNT_W_DEF constants.
  - The FSM state enum typedef (IDLE, RUN, DRAIN, DONE).
  - The accumulator width function SUM_W+CNT_W.
- One sub-module, adder_err_dist: purely combinational absolute-difference and nonzero-flag logic, instantiated in S1.

Test Plan:
- Reset check: assert rst_n=0 mid-RUN after 3 transfers -> next cycle state IDLE, in_ready=0, err_cnt=sum_ed=max_ed=0, done=0.
- Exact match: start num_samples=4; pairs (100,100),(0,0),(65535,65535),(131071,131071) -> done with err_cnt=0, sum_ed=0, max_ed=0.
- Mixed errors: num_samples=3; pairs (10,8),(5,9),(7,7) -> err_cnt=2, sum_ed=6, max_ed=4; done exactly 3 cycles after the 3rd transfer.
- Extremes and backpressure: num_samples=2; pairs (131071,0),(0,131071) with in_valid toggling 1,0,1 -> sum_ed=262142, max_ed=131071; a 3rd valid is not accepted (in_ready=0).
- Zero window and restart: start with num_samples=0 -> done next cycle, all zero. start again with num_samples=1 and pair (3,1) -> statistics cleared, then err_cnt=1, sum_ed=2.
- Ignored start: pulse start in RUN with num_samples=5 while the target is 2 -> window ends after 2 transfers. With ADDER_ERR_SQUARED_EN defined, pairs (10,8),(5,9) -> sum_sq_ed=20.
